// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Port 0 is the core load/store path, port 1 is the program/data loader.
package dmem_arb_pkg;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    localparam int PORT_LSU      = 0;
    localparam int PORT_LDR      = 1;
    localparam int DEFAULT_DEPTH = 64;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; mask restricts which requesters may win,
// last names the port that won most recently (the other one wins a tie).
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic [1:0] mask,
    output logic [1:0] gnt
);

    logic [1:0] req_m;

    assign req_m = req & mask;

    always_comb begin
        gnt = 2'b00;
        case (req_m)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-cycle data memory between the LSU and the loader with
// round-robin selection, bounded locking and address screening.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_0,
    input  logic        we_0,
    input  logic        lock_0,
    input  logic [31:0] addr_0,
    input  logic [31:0] wdata_0,
    output logic        gnt_0,
    output logic        rvalid_0,
    output logic [31:0] rdata_0,
    output logic        err_0,
    input  logic        req_1,
    input  logic        we_1,
    input  logic        lock_1,
    input  logic [31:0] addr_1,
    input  logic [31:0] wdata_1,
    output logic        gnt_1,
    output logic        rvalid_1,
    output logic [31:0] rdata_1,
    output logic        err_1,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_write_enable,
    input  logic [31:0] mem_read_data
);

    localparam int              CW      = $clog2(MAX_HOLD + 1);
    localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_HOLD);
    localparam logic [31:0]     DEPTH_W = 32'(DEPTH);

    arb_state_e    state_q, state_d;
    logic          owner_q, owner_d;
    logic          rr_last_q, rr_last_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic [CW-1:0] hold_inc;

    logic [1:0]    req_v;
    logic [1:0]    hold_mask;
    logic [1:0]    gnt;
    logic          any_gnt;
    logic          sel;
    logic [31:0]   addr_sel;
    logic [31:0]   wdata_sel;
    logic          we_sel;
    logic          lock_sel;
    logic          lock_owner;
    logic [31:0]   word_idx;
    logic          bad;
    logic [31:0]   resp_data;

    // Gating with reset keeps grants and the memory bus quiet while held in reset.
    assign req_v     = {req_1, req_0} & {2{reset}};
    assign hold_mask = (state_q == HOLD) ? (owner_q ? 2'b10 : 2'b01) : 2'b11;

    rr_arb2 u_pick (
        .req  (req_v),
        .last (rr_last_q),
        .mask (hold_mask),
        .gnt  (gnt)
    );

    assign gnt_0   = gnt[PORT_LSU];
    assign gnt_1   = gnt[PORT_LDR];
    assign any_gnt = |gnt;
    assign sel     = gnt[PORT_LDR];

    assign addr_sel   = sel ? addr_1  : addr_0;
    assign wdata_sel  = sel ? wdata_1 : wdata_0;
    assign we_sel     = sel ? we_1    : we_0;
    assign lock_sel   = sel ? lock_1  : lock_0;
    assign lock_owner = owner_q ? lock_1 : lock_0;

    assign word_idx = {2'b00, addr_sel[31:2]};
    assign bad      = (addr_sel[1:0] != 2'b00) || (word_idx >= DEPTH_W);

    assign mem_address      = any_gnt ? word_idx  : 32'h0;
    assign mem_write_data   = any_gnt ? wdata_sel : 32'h0;
    assign mem_write_enable = any_gnt & we_sel & ~bad;

    assign resp_data = (!we_sel && !bad) ? mem_read_data : 32'h0;
    assign hold_inc  = hold_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_last_d  = rr_last_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ARB: begin
                if (any_gnt) begin
                    rr_last_d = sel;
                    // With a budget of one access a lock has nothing left to hold.
                    if (lock_sel && (MAX_HOLD > 1)) begin
                        state_d    = HOLD;
                        owner_d    = sel;
                        hold_cnt_d = CW'(1);
                    end
                end
            end
            HOLD: begin
                if (any_gnt) begin
                    hold_cnt_d = hold_inc;
                end
                if (!lock_owner || (any_gnt && (hold_inc == MAX_CNT))) begin
                    state_d    = ARB;
                    rr_last_d  = owner_q;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d    = ARB;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ARB;
            owner_q    <= 1'b0;
            rr_last_q  <= 1'b1;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_last_q  <= rr_last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_resp
            logic        rvalid_q;
            logic        err_q;
            logic [31:0] rdata_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rvalid_q <= 1'b0;
                    err_q    <= 1'b0;
                    rdata_q  <= 32'h0;
                end else begin
                    rvalid_q <= gnt[gi];
                    err_q    <= gnt[gi] & bad;
                    if (gnt[gi]) begin
                        rdata_q <= resp_data;
                    end
                end
            end
        end
    endgenerate

    assign rvalid_0 = g_resp[0].rvalid_q;
    assign err_0    = g_resp[0].err_q;
    assign rdata_0  = g_resp[0].rdata_q;
    assign rvalid_1 = g_resp[1].rvalid_q;
    assign err_1    = g_resp[1].err_q;
    assign rdata_1  = g_resp[1].rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic, checked
// against a queue-based reference model with a response scoreboard.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int          DEPTH    = DEFAULT_DEPTH;
    localparam int          MAX_HOLD = 8;
    localparam logic [31:0] DEPTH_W  = 32'(DEPTH);

    typedef struct {
        bit          we;
        bit          lock;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        int          due;
        bit          err;
        logic [31:0] rdata;
    } resp_t;

    logic        clk;
    logic        reset;
    logic        req_0, we_0, lock_0, req_1, we_1, lock_1;
    logic [31:0] addr_0, wdata_0, addr_1, wdata_1;
    logic        gnt_0, rvalid_0, err_0, gnt_1, rvalid_1, err_1;
    logic [31:0] rdata_0, rdata_1;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_write_enable;

    int          checks = 0;
    int          passes = 0;
    int          cyc = 0;

    req_t        pq [2][$];
    resp_t       sb [2][$];
    bit          idle_lock [2];
    int          burst_left [2];
    int          gnt_log [$];
    logic [31:0] last_mem_addr;
    bit          we_seen;

    // reference arbitration state
    bit          m_locked;
    int          m_owner;
    int          m_count;
    int          m_last;

    logic [31:0] env_mem [DEPTH];
    logic [31:0] model_mem [DEPTH];

    dmem_arbiter #(.DEPTH(DEPTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_0            (req_0),
        .we_0             (we_0),
        .lock_0           (lock_0),
        .addr_0           (addr_0),
        .wdata_0          (wdata_0),
        .gnt_0            (gnt_0),
        .rvalid_0         (rvalid_0),
        .rdata_0          (rdata_0),
        .err_0            (err_0),
        .req_1            (req_1),
        .we_1             (we_1),
        .lock_1           (lock_1),
        .addr_1           (addr_1),
        .wdata_1          (wdata_1),
        .gnt_1            (gnt_1),
        .rvalid_1         (rvalid_1),
        .rdata_1          (rdata_1),
        .err_1            (err_1),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_read_data    (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // single-cycle memory behind the arbiter
    assign mem_read_data = (mem_address < DEPTH_W) ? env_mem[mem_address[5:0]] : 32'hBAD0_BAD0;
    always @(posedge clk) begin
        if (mem_write_enable && (mem_address < DEPTH_W))
            env_mem[mem_address[5:0]] <= mem_write_data;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    task automatic check_port(input int p, input logic v, input logic e, input logic [31:0] d);
        resp_t r;
        bit    exp_v;
        while (sb[p].size() > 0 && sb[p][0].due < cyc) begin
            checks++;
            $display("FAIL resp%0d_missing: rvalid=0 required=1 (due cycle %0d)", p, sb[p][0].due);
            void'(sb[p].pop_front());
        end
        exp_v = (sb[p].size() > 0) && (sb[p][0].due == cyc);
        if (exp_v || v) begin
            checks++;
            r.due = 0; r.err = 1'b0; r.rdata = 32'h0;
            if (exp_v) r = sb[p].pop_front();
            if (v && exp_v && (e == r.err) && (d == r.rdata)) begin
                passes++;
                $display("cycle %0d port %0d response err=%0b rdata=%h ok", cyc, p, e, d);
            end else begin
                $display("FAIL resp%0d: rvalid=%0b err=%0b rdata=%h required rvalid=%0b err=%0b rdata=%h",
                         p, v, e, d, exp_v, r.err, r.rdata);
            end
        end
    endtask

    always @(negedge clk) begin
        check_port(0, rvalid_0, err_0, rdata_0);
        check_port(1, rvalid_1, err_1, rdata_1);
    end

    task automatic run_cycle();
        req_t        cur [2];
        bit          has [2];
        bit          lk [2];
        int          g;
        int          act_g;
        bit          bad;
        logic [31:0] idx;
        logic [1:0]  exp_gnt;
        logic [31:0] exp_addr, exp_wd;
        logic        exp_we;
        resp_t       r;
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            has[p] = pq[p].size() > 0;
            cur[p] = '{we: 1'b0, lock: 1'b0, addr: 32'h0, wdata: 32'h0};
            if (has[p]) cur[p] = pq[p][0];
            lk[p] = has[p] ? cur[p].lock : idle_lock[p];
        end
        req_0 = has[0]; we_0 = cur[0].we; lock_0 = lk[0]; addr_0 = cur[0].addr; wdata_0 = cur[0].wdata;
        req_1 = has[1]; we_1 = cur[1].we; lock_1 = lk[1]; addr_1 = cur[1].addr; wdata_1 = cur[1].wdata;
        #2;
        g = -1;
        if (m_locked) begin
            if (has[m_owner]) g = m_owner;
        end else if (has[0] && has[1]) g = 1 - m_last;
        else if (has[0]) g = 0;
        else if (has[1]) g = 1;

        exp_gnt = 2'b00; exp_addr = 32'h0; exp_wd = 32'h0; exp_we = 1'b0; bad = 1'b0; idx = 32'h0;
        if (g >= 0) begin
            exp_gnt[g] = 1'b1;
            idx        = cur[g].addr >> 2;
            bad        = (cur[g].addr % 4 != 0) || (idx >= DEPTH_W);
            exp_addr   = idx;
            exp_wd     = cur[g].wdata;
            exp_we     = cur[g].we && !bad;
        end
        chk("gnt", 64'({gnt_1, gnt_0}), 64'(exp_gnt));
        chk("mem_addr_wdata", {mem_address, mem_write_data}, {exp_addr, exp_wd});
        chk("mem_we", 64'(mem_write_enable), 64'(exp_we));
        last_mem_addr = mem_address;
        we_seen       = we_seen | mem_write_enable;
        act_g = gnt_1 ? 1 : (gnt_0 ? 0 : -1);
        gnt_log.push_back(act_g);
        if (g >= 0) begin
            $display("cycle %0d grant port %0d we=%0b addr=%h", cyc, g, cur[g].we, cur[g].addr);
            r.due   = cyc + 1;
            r.err   = bad;
            r.rdata = (!cur[g].we && !bad) ? model_mem[idx[5:0]] : 32'h0;
            sb[g].push_back(r);
            if (cur[g].we && !bad) model_mem[idx[5:0]] = cur[g].wdata;
            void'(pq[g].pop_front());
        end
        if (!m_locked) begin
            if (g >= 0) begin
                m_last = g;
                if (lk[g] && MAX_HOLD > 1) begin
                    m_locked = 1'b1; m_owner = g; m_count = 1;
                end
            end
        end else begin
            if (g >= 0) m_count++;
            if (!lk[m_owner] || (g >= 0 && m_count == MAX_HOLD)) begin
                m_locked = 1'b0; m_last = m_owner; m_count = 0;
            end
        end
    endtask

    task automatic drain(input string name);
        int k = 0;
        while ((pq[0].size() > 0 || pq[1].size() > 0) && k < 64) begin
            run_cycle();
            k++;
        end
        chk({name, "_drain"}, 64'(pq[0].size() + pq[1].size()), 64'd0);
    endtask

    task automatic push_req(input int p, input bit we, input bit lock,
                            input logic [31:0] addr, input logic [31:0] wdata);
        req_t r;
        r.we = we; r.lock = lock; r.addr = addr; r.wdata = wdata;
        pq[p].push_back(r);
    endtask

    task automatic new_req(input int p);
        int          kind;
        int          w;
        logic [31:0] a;
        bit          lk;
        kind = int'($urandom_range(0, 15));
        w    = int'($urandom_range(0, 15));
        if (kind == 0)     a = 32'((DEPTH + int'($urandom_range(0, 15))) * 4);
        else if (kind < 3) a = 32'(w * 4 + int'($urandom_range(1, 3)));
        else               a = 32'(w * 4);
        if (burst_left[p] == 0 && $urandom_range(0, 3) == 0) burst_left[p] = int'($urandom_range(2, 12));
        lk = burst_left[p] > 1;
        if (burst_left[p] > 0) burst_left[p]--;
        push_req(p, $urandom_range(0, 1) == 1, lk, a, $urandom);
    endtask

    task automatic model_reset();
        m_locked = 1'b0; m_owner = 0; m_count = 0; m_last = 1;
    endtask

    initial begin
        int         lock_exp [13];
        logic [5:0] seq;
        int         mism;
        reset = 1'b0;
        req_0 = 1'b1; we_0 = 1'b0; lock_0 = 1'b0; addr_0 = 32'h0; wdata_0 = 32'h0;
        req_1 = 1'b1; we_1 = 1'b0; lock_1 = 1'b0; addr_1 = 32'h0; wdata_1 = 32'h0;
        idle_lock[0] = 1'b0; idle_lock[1] = 1'b0;
        burst_left[0] = 0; burst_left[1] = 0;
        we_seen = 1'b0;
        last_mem_addr = 32'h0;
        model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            env_mem[i]   = 32'hA500_0000 | 32'(i);
            model_mem[i] = 32'hA500_0000 | 32'(i);
        end

        // outputs held quiet in reset even with requests raised
        #3;
        chk("reset_ctl", 64'({gnt_0, gnt_1, rvalid_0, rvalid_1, err_0, err_1, mem_write_enable}), 64'd0);
        chk("reset_rdata", {rdata_0, rdata_1}, 64'd0);
        chk("reset_mem", {mem_address, mem_write_data}, 64'd0);
        req_0 = 1'b0; req_1 = 1'b0;
        @(posedge clk); #1 reset = 1'b1;

        // write then read back on port 0
        push_req(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        run_cycle();
        chk("wr_gnt_port", 64'(gnt_log[$]), 64'd0);
        push_req(0, 1'b0, 1'b0, 32'h10, 32'h0);
        run_cycle();
        chk("rd_mem_address", 64'(last_mem_addr), 64'd4);
        run_cycle();
        chk("rd_rvalid_rdata", {31'b0, rvalid_0, rdata_0}, {31'b0, 1'b1, 32'hDEADBEEF});

        // alternation under continuous contention
        push_req(1, 1'b0, 1'b0, 32'h10, 32'h0);
        run_cycle();
        gnt_log.delete();
        for (int i = 0; i < 4; i++) begin
            push_req(0, 1'b0, 1'b0, 32'(4 * i), 32'h0);
            push_req(1, 1'b0, 1'b0, 32'(4 * i + 16), 32'h0);
        end
        seq = 6'b0;
        for (int i = 0; i < 6; i++) begin
            run_cycle();
            seq = {seq[4:0], gnt_log[$] == 1};
        end
        chk("alternate_seq", 64'(seq), 64'(6'b010101));
        drain("alt");

        // locked burst on port 1 against steady port 0 reads
        gnt_log.delete();
        for (int i = 0; i < 10; i++) push_req(1, 1'b1, i < 9, 32'(32 + 4 * i), 32'hC0DE_0000 + 32'(i));
        run_cycle();
        for (int i = 0; i < 3; i++) push_req(0, 1'b0, 1'b0, 32'(32 + 4 * i), 32'h0);
        drain("lock");
        lock_exp = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 0, 0};
        mism = 0;
        for (int i = 0; i < 13; i++)
            if (i >= gnt_log.size() || gnt_log[i] != lock_exp[i]) mism++;
        chk("lock_seq_mismatches", 64'(mism), 64'd0);

        // misaligned and out-of-range writes never reach memory
        we_seen = 1'b0;
        push_req(1, 1'b1, 1'b0, 32'h102, 32'h55);
        push_req(1, 1'b1, 1'b0, 32'h100, 32'h55);
        push_req(1, 1'b1, 1'b0, 32'h12, 32'h55);
        drain("bad");
        run_cycle();
        chk("bad_write_enable", 64'(we_seen), 64'd0);
        push_req(1, 1'b0, 1'b0, 32'h10, 32'h0);
        drain("bad_readback");

        // reset in the middle of a locked burst with a response outstanding
        for (int i = 0; i < 3; i++) push_req(1, 1'b0, 1'b1, 32'(8 * i), 32'h0);
        run_cycle();
        run_cycle();
        chk("pre_reset_rvalid", 64'(rvalid_1), 64'd1);
        reset = 1'b0;
        #1;
        chk("hold_reset_ctl", 64'({gnt_0, gnt_1, rvalid_0, rvalid_1, err_0, err_1, mem_write_enable}), 64'd0);
        chk("hold_reset_data", {rdata_0, rdata_1}, 64'd0);
        chk("hold_reset_mem", {mem_address, mem_write_data}, 64'd0);
        pq[0].delete(); pq[1].delete(); sb[0].delete(); sb[1].delete();
        model_reset();
        req_0 = 1'b0; req_1 = 1'b0; lock_0 = 1'b0; lock_1 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        push_req(0, 1'b0, 1'b0, 32'h4, 32'h0);
        push_req(1, 1'b0, 1'b0, 32'h8, 32'h0);
        run_cycle();
        chk("post_reset_first_gnt", 64'(gnt_log[$]), 64'd0);
        drain("post_reset");

        // random traffic
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (pq[p].size() == 0 && $urandom_range(0, 2) != 0) new_req(p);
                idle_lock[p] = $urandom_range(0, 3) == 0;
            end
            run_cycle();
        end
        idle_lock[0] = 1'b0; idle_lock[1] = 1'b0;
        drain("random");
        run_cycle();
        run_cycle();

        mism = 0;
        for (int i = 0; i < DEPTH; i++)
            if (env_mem[i] !== model_mem[i]) mism++;
        chk("mem_contents_mismatches", 64'(mism), 64'd0);
        chk("scoreboard_left", 64'(sb[0].size() + sb[1].size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (passed %0d of %0d)", passes, checks);
        $fatal(1, "timeout");
    end

endmodule
